dcc_ce_seq: RTL and testbench
=============================

DCC_CE_SEQ -- requirements
Module: dcc_ce_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 4: clki cycles between ce0 and ce1 edges; legal range 1..255.
REQ-002 SHALL have parameter MIN_HOLD, default 8: minimum clki cycles in ON and in OFF before the next transition; legal range 1..255.
REQ-003 SHALL have port clki, input, 1: sole clock; all flops on the rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, 1: level request for gated clock on; asynchronous to clki.
REQ-006 SHALL have port ce0, output, 1: CE of the first (upstream) DCCA in the cascade.
REQ-007 SHALL have port ce1, output, 1: CE of the second (downstream) DCCA in the cascade.
REQ-008 SHALL have port ack, output, 1: gated clock fully on.
REQ-009 SHALL have port busy, output, 1: enable or disable sequence in progress.

Function
REQ-010 SHALL synchronise req through two clki flops (req_s); only req_s drives decisions.
REQ-011 SHALL implement states OFF, EN0, ON, DIS1, with one 8-bit down-counter cnt shared by all states.
REQ-012 SHALL drive all outputs from flops, with no combinational path from req to any output.
REQ-013 Outputs per state SHALL be: OFF ce0=0 ce1=0; EN0 ce0=1 ce1=0; ON ce0=1 ce1=1; DIS1 ce0=1 ce1=0.
REQ-014 Per state, ack SHALL be 1 only in ON, and busy SHALL be 1 only in EN0 and DIS1.
REQ-015 OFF->EN0 SHALL occur when req_s=1 and cnt=0; on entry cnt=SETTLE-1.
REQ-016 In EN0, cnt>0 SHALL decrement cnt each cycle.
REQ-017 EN0->ON SHALL occur when cnt=0 and req_s=1; on entry cnt=MIN_HOLD-1.
REQ-018 EN0->OFF (abort) SHALL occur on any cycle with req_s=0, deasserting ce0 at the next edge; on entry cnt=MIN_HOLD-1.
REQ-019 In ON, cnt SHALL decrement to 0 and then hold.
REQ-020 ON->DIS1 SHALL occur when cnt=0 and req_s=0; on entry cnt=SETTLE-1.
REQ-021 req_s=0 in ON while cnt>0 SHALL be held off until cnt=0.
REQ-022 In DIS1, cnt SHALL decrement, and DIS1->OFF SHALL occur at cnt=0; on entry cnt=MIN_HOLD-1.
REQ-023 req_s reassertion during DIS1 SHALL be ignored until OFF hold expires.
REQ-024 In OFF, cnt SHALL decrement to 0 and then hold.
REQ-025 Enable ordering SHALL be ce0 rise, then exactly SETTLE cycles later ce1 rise; disable SHALL be the exact reverse, ce1 fall then SETTLE cycles later ce0 fall.
REQ-026 ce1=1 while ce0=0 SHALL never occur.
REQ-027 Latency from an idle OFF (cnt=0) SHALL be: req high before edge k gives ce0=1 after edge k+2.
REQ-028 Latency from ON (cnt=0) SHALL be: req low before edge k gives ce1=0 after edge k+2.
REQ-029 A req pulse shorter than one clki period MAY be missed; a pulse of 2 or more cycles SHALL be seen.
REQ-030 SETTLE=1 and MIN_HOLD=1 SHALL give a single-cycle EN0/DIS1 and no extra hold cycles.

Reset
REQ-031 rstn=0 SHALL immediately force state=OFF, cnt=0, sync flops=0, and ce0=ce1=ack=busy=0, independent of clki.
REQ-032 Reset asserted mid-sequence (EN0, ON, DIS1) SHALL drop ce1 and ce0 together, asynchronously.
REQ-033 After rstn release, the first req_s=1 SHALL be accepted immediately, with no hold.
REQ-034 rstn deassertion SHALL be treated as synchronous to clki by the integrator; the block adds no reset synchroniser.

Verification
REQ-035 Bench SHALL cover basic on: SETTLE=4, MIN_HOLD=8, req 0->1 before edge 10 -> ce0=1 after edge 12, ce1=ack=1 after edge 16, busy=1 after edges 12..15.
REQ-036 Bench SHALL cover min-on hold: req 1 for 3 cycles after ack -> ce1 stays 1 until cnt=0 (8 cycles after ack), then ce1 falls, ce0 falls 4 cycles later, ack=0 with ce1.
REQ-037 Bench SHALL cover abort: req drops 2 cycles after ce0 rise -> ce1 never asserts, ce0 falls 2 edges after req_s=0, OFF hold of 8 cycles before re-enable.
REQ-038 Bench SHALL cover request during DIS1: req reasserts in DIS1 -> DIS1 completes, OFF hold of 8 cycles, then EN0 entered with ce0 rising exactly 1 edge after cnt reaches 0.
REQ-039 Bench SHALL cover reset mid-ON: rstn=0 between clki edges -> ce0, ce1, ack at 0 before the next clki edge; after release with req=1, ce0 rises 3 edges later.
REQ-040 Bench SHALL check corner parameters SETTLE=1, MIN_HOLD=1: 1-cycle ce0-only window on enable and disable; the ce1-without-ce0 assertion never fires over 10k random req cycles.

Source files
------------

// File: rtl/dcc_ce_seq.sv
// rtl/dcc_ce_seq.sv - two-stage DCCA clock-enable sequencer with settle and minimum-hold timing
// ce0 always leads ce1 on enable and trails it on disable; one shared down-counter times every state.
module dcc_ce_seq #(
  parameter int SETTLE   = 4,
  parameter int MIN_HOLD = 8
) (
  input  logic clki,
  input  logic rstn,
  input  logic req,
  output logic ce0,
  output logic ce1,
  output logic ack,
  output logic busy
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    EN0  = 2'd1,
    ON   = 2'd2,
    DIS1 = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [7:0] HOLD_LD   = 8'(MIN_HOLD - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       req_m;
  logic       req_s;

  // req is asynchronous to clki; only req_s may steer the sequencer.
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      req_m <= 1'b0;
      req_s <= 1'b0;
    end else begin
      req_m <= req;
      req_s <= req_m;
    end
  end

  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      state <= OFF;
      cnt   <= 8'd0;
      ce0   <= 1'b0;
      ce1   <= 1'b0;
      ack   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (req_s) begin
            state <= EN0;
            cnt   <= SETTLE_LD;
            ce0   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        EN0: begin
          // A dropped request aborts before ce1 ever rises.
          if (!req_s) begin
            state <= OFF;
            cnt   <= HOLD_LD;
            ce0   <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == 8'd0) begin
            state <= ON;
            cnt   <= HOLD_LD;
            ce1   <= 1'b1;
            ack   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ON: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (!req_s) begin
            state <= DIS1;
            cnt   <= SETTLE_LD;
            ce1   <= 1'b0;
            ack   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        DIS1: begin
          // Runs to completion regardless of req_s.
          if (cnt == 8'd0) begin
            state <= OFF;
            cnt   <= HOLD_LD;
            ce0   <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= OFF;
          cnt   <= 8'd0;
          ce0   <= 1'b0;
          ce1   <= 1'b0;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcc_ce_seq.sv
// tb/tb_dcc_ce_seq.sv - self-checking bench for dcc_ce_seq (default and SETTLE=1/MIN_HOLD=1 instances)
module tb_dcc_ce_seq;

  logic clki;
  logic rstn_a, rstn_b;
  logic req_a, req_b;
  logic a_ce0, a_ce1, a_ack, a_busy;
  logic b_ce0, b_ce1, b_ack, b_busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit a_ce1_seen = 0;

  dcc_ce_seq #(.SETTLE(4), .MIN_HOLD(8)) dut_a (
    .clki(clki), .rstn(rstn_a), .req(req_a),
    .ce0(a_ce0), .ce1(a_ce1), .ack(a_ack), .busy(a_busy)
  );

  dcc_ce_seq #(.SETTLE(1), .MIN_HOLD(1)) dut_b (
    .clki(clki), .rstn(rstn_b), .req(req_b),
    .ce0(b_ce0), .ce1(b_ce1), .ack(b_ack), .busy(b_busy)
  );

  initial begin
    clki = 1'b0;
    forever #5 clki = ~clki;
  end

  always @(posedge clki) cyc++;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tracks how many CEs are on and the edge number of the
  // last transition, and applies the timing rules as elapsed-edge comparisons.
  typedef struct {
    int level;
    bit dis;
    int t;
    bit h1;
    bit h2;
  } mdl_t;

  function automatic mdl_t mstep(input mdl_t m, input bit r, input int n,
                                 input int st, input int mh);
    mdl_t o;
    bit   rs;
    o    = m;
    rs   = m.h2;
    o.h2 = m.h1;
    o.h1 = r;
    if (m.level == 0) begin
      if (rs && (n - m.t) >= mh) begin o.level = 1; o.dis = 0; o.t = n; end
    end else if (m.level == 1) begin
      if (m.dis) begin
        if ((n - m.t) >= st) begin o.level = 0; o.t = n; end
      end else if (!rs) begin
        o.level = 0; o.t = n;
      end else if ((n - m.t) >= st) begin
        o.level = 2; o.t = n;
      end
    end else begin
      if (!rs && (n - m.t) >= mh) begin o.level = 1; o.dis = 1; o.t = n; end
    end
    return o;
  endfunction

  function automatic logic [3:0] mexp(input mdl_t m);
    return {m.level >= 1, m.level == 2, m.level == 2, m.level == 1};
  endfunction

  function automatic mdl_t mreset(input int n);
    mdl_t o;
    o.level = 0; o.dis = 0; o.t = n - 1000; o.h1 = 0; o.h2 = 0;
    return o;
  endfunction

  mdl_t ma, mb;
  int   na = 0, nb = 0;

  always @(posedge clki or negedge rstn_a) begin
    if (!rstn_a) ma = mreset(na);
    else begin na++; ma = mstep(ma, req_a, na, 4, 8); end
  end

  always @(posedge clki or negedge rstn_b) begin
    if (!rstn_b) mb = mreset(nb);
    else begin nb++; mb = mstep(mb, req_b, nb, 1, 1); end
  end

  always @(negedge clki) begin
    if (rstn_a) chk4("model_a", {a_ce0, a_ce1, a_ack, a_busy}, mexp(ma));
    if (rstn_b) chk4("model_b", {b_ce0, b_ce1, b_ack, b_busy}, mexp(mb));
    chk4("ce1_without_ce0_a", {3'b0, a_ce1 & ~a_ce0}, 4'b0);
    chk4("ce1_without_ce0_b", {3'b0, b_ce1 & ~b_ce0}, 4'b0);
    if (a_ce1) a_ce1_seen = 1;
  end

  function automatic bit sig(input int w);
    case (w)
      0:       return a_ce0;
      1:       return a_ce1;
      2:       return b_ce0;
      default: return b_ce1;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int w, input bit v,
                          input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clki);
      if (sig(w) == v) begin
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d cycles, required value %0d", name, bound, v);
  endtask

  typedef struct {
    bit req;
    bit ce0;
    bit ce1;
    bit ack;
    bit busy;
  } vec_t;

  vec_t tbl[1:32];

  initial begin
    int e, f, g, h, r, d, x, y;
    int ra_len, rb_len;

    for (int i = 1; i <= 32; i++) begin
      tbl[i].req  = (i >= 10 && i <= 19);
      tbl[i].ce0  = (i >= 12 && i <= 27);
      tbl[i].ce1  = (i >= 16 && i <= 23);
      tbl[i].ack  = (i >= 16 && i <= 23);
      tbl[i].busy = (i >= 12 && i <= 15) || (i >= 24 && i <= 27);
    end

    rstn_a = 0; rstn_b = 0; req_a = 0; req_b = 0;
    repeat (3) @(negedge clki);
    chk4("reset_a", {a_ce0, a_ce1, a_ack, a_busy}, 4'b0);
    chk4("reset_b", {b_ce0, b_ce1, b_ack, b_busy}, 4'b0);
    rstn_a = 1; rstn_b = 1;

    // Basic enable then minimum-on hold and disable, edge by edge.
    for (int i = 1; i <= 32; i++) begin
      req_a = tbl[i].req;
      @(negedge clki);
      chk4($sformatf("tbl_edge%0d", i), {a_ce0, a_ce1, a_ack, a_busy},
           {tbl[i].ce0, tbl[i].ce1, tbl[i].ack, tbl[i].busy});
    end

    // Abort during EN0.
    repeat (10) @(negedge clki);
    a_ce1_seen = 0;
    req_a = 1;
    wait_sig("abort_ce0_rise", 0, 1'b1, 20, e);
    req_a = 0;
    wait_sig("abort_ce0_fall", 0, 1'b0, 20, f);
    chki("abort_fall_edges", f - e, 3);
    chki("abort_no_ce1", int'(a_ce1_seen), 0);
    req_a = 1;
    wait_sig("abort_reenable", 0, 1'b1, 30, g);
    chki("abort_off_hold", g - f, 8);
    wait_sig("abort_then_on", 1, 1'b1, 20, h);
    chki("enable_settle", h - g, 4);
    repeat (12) @(negedge clki);

    // Request reasserted during DIS1.
    r = cyc;
    req_a = 0;
    wait_sig("dis_ce1_fall", 1, 1'b0, 20, d);
    chki("dis_latency", d - r, 3);
    req_a = 1;
    wait_sig("dis_ce0_fall", 0, 1'b0, 20, x);
    chki("dis_settle", x - d, 4);
    wait_sig("dis_reenable", 0, 1'b1, 30, y);
    chki("dis_off_hold", y - x, 8);
    wait_sig("dis_then_on", 1, 1'b1, 20, h);
    repeat (3) @(negedge clki);

    // Asynchronous reset while ON, then release with req held high.
    @(posedge clki);
    #2 rstn_a = 0;
    #1 chk4("rst_async_drop", {a_ce0, a_ce1, a_ack, 1'b0}, 4'b0);
    @(negedge clki);
    rstn_a = 1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clki);
      chk4($sformatf("rst_release_edge%0d", k), {3'b0, a_ce0}, {3'b0, k == 3});
    end

    // SETTLE=1, MIN_HOLD=1: single-cycle ce0-only windows.
    req_b = 1;
    wait_sig("corner_ce0_rise", 2, 1'b1, 20, e);
    chk4("corner_busy_en", {b_ce1, b_busy, 2'b0}, 4'b0100);
    wait_sig("corner_ce1_rise", 3, 1'b1, 20, h);
    chki("corner_en_window", h - e, 1);
    req_b = 0;
    wait_sig("corner_ce1_fall", 3, 1'b0, 20, f);
    wait_sig("corner_ce0_fall", 2, 1'b0, 20, g);
    chki("corner_dis_window", g - f, 1);

    // Random request levels on both instances against the reference model.
    ra_len = 0;
    rb_len = 0;
    for (int i = 0; i < 10000; i++) begin
      if (ra_len == 0) begin
        req_a  = 1'($urandom_range(0, 1));
        ra_len = $urandom_range(1, 14);
      end
      if (rb_len == 0) begin
        req_b  = 1'($urandom_range(0, 1));
        rb_len = $urandom_range(1, 6);
      end
      ra_len--;
      rb_len--;
      @(negedge clki);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
